// File: rtl/bcd_seg_scanner_if.sv
// Bundle of the digit-load and display signals of the seven-segment scanner.
// The master side (upstream BCD stage or testbench) drives load/h/t/o.
// The slave side (the scanner) drives the multiplexed segment and anode bus.
interface bcd_seg_scanner_if;
    logic       load;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] seg;
    logic [2:0] an;

    modport master (output load, output h, output t, output o, input seg, input an);
    modport slave  (input load, input h, input t, input o, output seg, output an);
endinterface

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed 3-digit seven-segment driver.
// - Latches hundreds/tens/ones BCD digits on bus.load.
// - Scans them onto a shared segment bus, one slot of CLK_DIV clocks per digit.
// - The first GUARD clocks of each slot keep every anode off to avoid ghosting.
// - seg and an are registered, so they show cnt/sel/latch state with one cycle of latency.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
// - When defined, the anodes of leading-zero digits (hundreds, then tens) are masked.
// - The ones digit is never blanked.
module bcd_seg_scanner #(
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_seg_scanner_if.slave bus
);

    localparam int               CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [6:0]       SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]       AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        ST_ONES = 2'd0,
        ST_TENS = 2'd1,
        ST_HUND = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;
    logic [3:0]       r_h;
    logic [3:0]       r_t;
    logic [3:0]       r_o;
    logic [3:0]       w_digit;
    logic [2:0]       w_onehot;
    logic [2:0]       w_mask;
    logic [2:0]       w_an_hi;
    logic             w_guard;
    logic [6:0]       r_seg;
    logic [2:0]       r_an;

    // Active-high segment pattern {g,f,e,d,c,b,a}; 10..15 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    // Slot counter wraps at CLK_DIV-1; the wrap is the only moment the digit select moves.
    assign w_wrap = (r_cnt == CNT_MAX);

    // Guard window: blank anodes while the slot counter is below GUARD.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
            assign w_guard = (r_cnt < GUARD_C);
        end
    endgenerate

    // Slot counter and scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_ONES;
        end else begin
            r_cnt   <= w_wrap ? {CNT_W{1'b0}} : (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
            r_state <= w_state_nxt;
        end
    end

    // Scan FSM next state: ONES -> TENS -> HUNDREDS -> ONES, advancing only on a slot wrap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ONES: begin
                if (w_wrap) w_state_nxt = ST_TENS;
                else        w_state_nxt = ST_ONES;
            end
            ST_TENS: begin
                if (w_wrap) w_state_nxt = ST_HUND;
                else        w_state_nxt = ST_TENS;
            end
            ST_HUND: begin
                if (w_wrap) w_state_nxt = ST_ONES;
                else        w_state_nxt = ST_HUND;
            end
            default: w_state_nxt = ST_ONES;
        endcase
    end

    // Digit latches; load held high simply re-latches every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 4'd0;
            r_t <= 4'd0;
            r_o <= 4'd0;
        end else if (bus.load) begin
            r_h <= bus.h;
            r_t <= bus.t;
            r_o <= bus.o;
        end else begin
            r_h <= r_h;
            r_t <= r_t;
            r_o <= r_o;
        end
    end

    // Select the digit and its one-hot anode {hundreds,tens,ones} for the current slot.
    always_comb begin
        w_digit  = r_o;
        w_onehot = 3'b001;
        case (r_state)
            ST_ONES: begin
                w_digit  = r_o;
                w_onehot = 3'b001;
            end
            ST_TENS: begin
                w_digit  = r_t;
                w_onehot = 3'b010;
            end
            ST_HUND: begin
                w_digit  = r_h;
                w_onehot = 3'b100;
            end
            default: begin
                w_digit  = r_o;
                w_onehot = 3'b001;
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_h_zero;
    logic w_t_zero;

    // Mask leading-zero anodes: hundreds when h==0, tens when h==0 and t==0.
    always_comb begin
        w_h_zero = (r_h == 4'd0);
        w_t_zero = (r_t == 4'd0);
        w_mask   = {w_h_zero, w_h_zero & w_t_zero, 1'b0};
    end
`else
    // All three digits are always shown, leading zeros included.
    always_comb begin
        w_mask = 3'b000;
    end
`endif

    // Active-high anode vector after guard blanking and leading-zero masking.
    always_comb begin
        if (w_guard) begin
            w_an_hi = 3'b000;
        end else begin
            w_an_hi = w_onehot & ~w_mask;
        end
    end

    // Output register with polarity applied; reset drives everything inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= ACTIVE_LOW ? ~seg_decode(w_digit) : seg_decode(w_digit);
            r_an  <= ACTIVE_LOW ? ~w_an_hi : w_an_hi;
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (CLK_DIV=4, GUARD=1, ACTIVE_LOW=1).
// Expected {an,seg} words are pushed to a scoreboard queue as each cycle's
// stimulus is driven and popped when the DUT output of that edge is sampled.
module tb_bcd_seg_scanner;

    localparam int CLK_DIV = 4;
    localparam int GUARD   = 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference state: edges since reset release and the digits the DUT should hold.
    int         m_k;
    logic [3:0] m_h;
    logic [3:0] m_t;
    logic [3:0] m_o;
    logic [9:0] sb_q[$];

    bcd_seg_scanner_if bus ();

    bcd_seg_scanner #(
        .CLK_DIV   (CLK_DIV),
        .GUARD     (GUARD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports a mismatch.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        else          return tab[d];
    endfunction

    // Expected {an,seg} after edge k+1 since release: shows the state after k edges.
    function automatic logic [9:0] model_out(input int k, input logic [3:0] dh,
                                             input logic [3:0] dt, input logic [3:0] dn);
        int         phase;
        int         slot;
        logic [2:0] an_hi;
        logic [3:0] d;
        phase = k % CLK_DIV;
        slot  = (k / CLK_DIV) % 3;
        if (slot == 0)      begin an_hi = 3'b001; d = dn; end
        else if (slot == 1) begin an_hi = 3'b010; d = dt; end
        else                begin an_hi = 3'b100; d = dh; end
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2 && dh == 4'd0) an_hi = 3'b000;
        if (slot == 1 && dh == 4'd0 && dt == 4'd0) an_hi = 3'b000;
`endif
        if (phase < GUARD) an_hi = 3'b000;
        return {~an_hi, ~ref_seg(d)};
    endfunction

    // One clock: drive inputs at negedge, push expectation, pop and compare after posedge.
    task automatic step(input logic ld, input logic [3:0] vh, input logic [3:0] vt,
                        input logic [3:0] vo, input string tag);
        logic [9:0] e;
        @(negedge clk);
        bus.load = ld;
        bus.h    = vh;
        bus.t    = vt;
        bus.o    = vo;
        sb_q.push_back(model_out(m_k, m_h, m_t, m_o));
        if (ld) begin
            m_h = vh;
            m_t = vt;
            m_o = vo;
        end
        m_k++;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {6'd0, bus.an, bus.seg}, {6'd0, e});
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), tag);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.h    = 4'd0;
        bus.t    = 4'd0;
        bus.o    = 4'd0;
        m_k = 0; m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;

        // 1. Reset held, then released just after an edge.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {13'd0, bus.an}, 16'h0007);
        chk("rst_seg", {9'd0, bus.seg}, 16'h007F);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 4'd0, 4'd0, "rel_edge1");
        chk("rel_edge1_an", {13'd0, bus.an}, 16'h0007);
        step(1'b0, 4'd0, 4'd0, 4'd0, "rel_edge2");
        chk("rel_edge2_an", {13'd0, bus.an}, 16'h0006);

        // 2. Load 1/2/8 and free-run through full scans.
        step(1'b1, 4'd1, 4'd2, 4'd8, "load128");
        idle(14, "scan128");

        // 3. Non-BCD ones digit shows a dash.
        step(1'b1, 4'd1, 4'd2, 4'hC, "load_dash");
        idle(12, "scan_dash");

        // 4. Load on the exact ONES->TENS wrap edge, tens 2 -> 7.
        step(1'b1, 4'd1, 4'd2, 4'd8, "reload128");
        while ((m_k % 12) != 3) step(1'b0, 4'd0, 4'd0, 4'd0, "to_wrap");
        step(1'b1, 4'd1, 4'd7, 4'd8, "load_on_wrap");
        idle(4, "tens_after_wrap");
        chk("tens_is_7", {9'd0, bus.seg}, {9'd0, ~7'h07});

        // Load held high re-latches every cycle.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i % 3), 4'(i % 10), 4'(9 - (i % 10)), "held_load");
        end

        // 5. Asynchronous reset in the middle of the HUNDREDS slot.
        step(1'b1, 4'd2, 4'd5, 4'd5, "load255");
        while ((m_k % 12) != 10) step(1'b0, 4'd0, 4'd0, 4'd0, "to_hund");
        chk("hund_active", {13'd0, bus.an}, 16'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {13'd0, bus.an}, 16'h0007);
        chk("async_rst_seg", {9'd0, bus.seg}, 16'h007F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_k = 0; m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
        idle(13, "after_rst_000");

        // 6. Leading-zero patterns (blanked only when the macro is defined).
        step(1'b1, 4'd0, 4'd0, 4'd5, "load005");
        idle(12, "scan005");
        step(1'b1, 4'd0, 4'd3, 4'd5, "load035");
        idle(12, "scan035");

        // Random loads interleaved with idle cycles.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
        end

        chk("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
